ofifo_collector: RTL
====================

Name: ofifo_collector

Overview:
- Receives the bottom-row partial sums (out_s) and per-column valid strobes from the systolic MAC array.
- Columns produce valid data at staggered cycles because of the array skew. The block re-aligns them into full rows.
- It is built as one independent FIFO per column. A full row is presented to the downstream reader (psum SRAM writer or SFU) only when every column holds data.
- This is the receive end of the array's south-side output interface.

Parameters:
- col, 8, number of columns; must match the MAC row width.
- psum_bw, 16, bits per partial sum.
- depth, 64, entries per column FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- in  input  psum_bw*col  per-column psum. Column i occupies bits [i*psum_bw +: psum_bw].
- wr  input  col  per-column write strobe, driven by the array's valid[col-1:0].
- rd  input  1  pop one full row.
- out  output  psum_bw*col  head row, same column packing as in.
- o_valid  output  1  every column FIFO is non-empty.
- o_full  output  1  at least one column FIFO is full.
- o_ready  output  1  equals ~o_full.
- o_overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (asynchronous, reset==0):
  - All read and write pointers go to 0.
  - o_overflow goes to 0.
  - Storage contents are don't-care.
  - Outputs during and after reset: o_valid=0, o_full=0, o_ready=1, out=0.
- Each column is a circular buffer. Read and write pointers are $clog2(depth)+1 bits wide, with the MSB used as the wrap bit.
  - Column empty: rptr == wptr.
  - Column full: the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*depth.
- Write to column i:
  - Occurs on a clock edge where wr[i]==1 and column i is not full.
  - Stores in[i] at wptr_i[low bits], then increments wptr_i.
  - Columns are written independently; any subset of wr may be asserted in a cycle.
- Write to a full column:
  - Data is dropped and the pointer is unchanged.
  - o_overflow is set to 1 on that edge and holds until reset.
  - The other columns written in the same cycle are unaffected.
- Read:
  - Occurs on an edge where rd==1 and o_valid==1. All col read pointers increment together.
  - rd while o_valid==0 is ignored: no pointer change, no error flag.
- Output timing:
  - out is show-ahead: it reflects the head entry of every column combinationally from storage.
  - out is 0 whenever o_valid==0.
  - The latency from the last column's write edge to o_valid==1 is 0 cycles after that edge, i.e. o_valid is visible in the following cycle.
- Simultaneous read and write on the same column:
  - Both take effect. The occupancy of that column is unchanged.
  - A full column that is also read in the same cycle still rejects the write, because full is evaluated before the edge. The write is dropped and o_overflow is set.
  - An empty column cannot be read, since o_valid would be 0. The write proceeds and the read is ignored.
- Flags: o_full, o_ready and o_valid are combinational from pointer state only; they are never derived from rd or wr.
- Reset asserted mid-operation: all occupancy is discarded immediately; there is no drain.
- Arithmetic: no modification of data. Psum values pass bit-exact, with no sign extension or truncation.

Decomposition:
- Shared package: the ptr width function ($clog2(depth)+1) and the column-slice width constant psum_bw.
- One natural sub-module: ofifo_column, a single-column FIFO instantiated col times with a generate loop.
  - Ports: clk, reset, wr, rd, in, out, empty, full, overflow.
  - Top level:
    - o_valid = AND of ~empty across columns.
    - o_full = OR of full across columns.
    - o_overflow = OR of the per-column sticky flags.
    - Each column's rd is driven by the top-level rd & o_valid.

Test Plan:
- Reset then idle → o_valid=0, o_full=0, o_ready=1, out=0, o_overflow=0.
- Staggered write:
  - Stimulus: wr=8'b0000_0001 at cycle 0, 0000_0011 at cycle 1, and so on up to 1111_1111 at cycle 7, then wr shifted off. Column i receives 16'h0100+i on each of its writes.
  - Required: o_valid=1 only after column 7's first write.
  - Required: out = {16'h0107,...,16'h0100}. rd=1 for one cycle then pops it.
- Fill column 0 with 64 writes (16'h0000..16'h003F) while the other columns are empty → o_full=1 and o_ready=0 after the 64th write.
- 65th write to column 0 (value 16'hDEAD) → dropped, o_overflow=1. Fill columns 1–7, then read: out column 0 = 16'h0000, never 16'hDEAD.
- rd=1 while o_valid=0 → no pointer change; a subsequent full-row write yields out equal to that row.
- Wrap-around:
  - 200 rows written with all columns at once, each row value k in every column. rd is asserted every cycle after the first row.
  - Required: out sequence 0..199 in order, o_overflow=0.
  - Reset pulsed low mid-stream → o_valid=0 in the same cycle, and the next written row reads back first.

Source files
------------

// File: rtl/ofifo_collector_pkg.sv
// Shared constants and helpers for the output-FIFO collector that re-aligns
// skewed column outputs of the systolic MAC array into full rows.
package ofifo_collector_pkg;

    localparam int default_col     = 8;
    localparam int default_psum_bw = 16;
    localparam int default_depth   = 64;

    // One extra pointer bit acts as the wrap flag that separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_column.sv
// Single-column circular FIFO with show-ahead output and a sticky overflow
// flag; a write to a full column is dropped.
module ofifo_column
    import ofifo_collector_pkg::*;
#(
    parameter int psum_bw = default_psum_bw,
    parameter int depth   = default_depth
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               overflow
);

    localparam int aw = $clog2(depth);
    localparam int pw = ptr_width(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [pw-1:0]      wptr;
    logic [pw-1:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    assign out   = mem[rptr[aw-1:0]];

    // Full is sampled before the edge, so a same-cycle read never makes room.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr && !full) wptr <= wptr + 1'b1;
            if (wr && full)  overflow <= 1'b1;
            if (rd && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !full) mem[wptr[aw-1:0]] <= in;
    end

endmodule

// File: rtl/ofifo_collector.sv
// Collects staggered per-column psums into aligned rows; a row is offered
// only once every column FIFO holds at least one entry.
module ofifo_collector
    import ofifo_collector_pkg::*;
#(
    parameter int col     = default_col,
    parameter int psum_bw = default_psum_bw,
    parameter int depth   = default_depth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    // Handshake: a row pops on a rising edge where rd && o_valid; o_ready
    // advertises that no column is full, and all flags depend only on pointers.
    logic [col-1:0]     empty_v;
    logic [col-1:0]     full_v;
    logic [col-1:0]     ovf_v;
    logic [psum_bw-1:0] col_out [col];
    logic               col_rd;

    assign col_rd     = rd & o_valid;
    assign o_valid    = &(~empty_v);
    assign o_full     = |full_v;
    assign o_ready    = ~o_full;
    assign o_overflow = |ovf_v;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_column #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr[i]),
            .rd       (col_rd),
            .in       (in[i*psum_bw +: psum_bw]),
            .out      (col_out[i]),
            .empty    (empty_v[i]),
            .full     (full_v[i]),
            .overflow (ovf_v[i])
        );

        assign out[i*psum_bw +: psum_bw] = o_valid ? col_out[i] : '0;
    end

endmodule
